// File: rtl/commit_ctrl_if.sv
// Commit-stage bundle: per-slot retire info in, commit mask / flush / CSR exception record / stall out.
interface commit_ctrl_if #(
  parameter int COMMIT_WIDTH = 2,
  parameter int EXCP_W       = 16
);
  logic [COMMIT_WIDTH-1:0]        slot_valid_i;
  logic [COMMIT_WIDTH-1:0]        slot_excp_i;
  logic [COMMIT_WIDTH-1:0]        slot_ertn_i;
  logic [COMMIT_WIDTH*EXCP_W-1:0] slot_excp_num_i;
  logic [COMMIT_WIDTH*32-1:0]     slot_pc_i;
  logic [COMMIT_WIDTH*32-1:0]     slot_instr_i;
  logic [COMMIT_WIDTH*32-1:0]     slot_badva_i;
  logic [COMMIT_WIDTH-1:0]        ex_stallreq_i;
  logic [COMMIT_WIDTH-1:0]        mem_stallreq_i;
  logic                           dispatch_stallreq_i;

  logic [COMMIT_WIDTH-1:0]        commit_mask_o;
  logic [4:0]                     stall_o;
  logic                           flush_o;
  logic                           excp_flush_o;
  logic                           ertn_flush_o;
  logic [31:0]                    csr_era_o;
  logic [5:0]                     csr_ecode_o;
  logic [8:0]                     csr_esubcode_o;
  logic                           va_error_o;
  logic [31:0]                    bad_va_o;
  logic                           excp_tlbrefill_o;
  logic                           excp_tlb_o;
  logic [18:0]                    excp_tlb_vppn_o;
  logic [31:0]                    excp_instr_o;

  modport master (
    output slot_valid_i, slot_excp_i, slot_ertn_i, slot_excp_num_i, slot_pc_i,
           slot_instr_i, slot_badva_i, ex_stallreq_i, mem_stallreq_i, dispatch_stallreq_i,
    input  commit_mask_o, stall_o, flush_o, excp_flush_o, ertn_flush_o, csr_era_o,
           csr_ecode_o, csr_esubcode_o, va_error_o, bad_va_o, excp_tlbrefill_o,
           excp_tlb_o, excp_tlb_vppn_o, excp_instr_o
  );

  modport slave (
    input  slot_valid_i, slot_excp_i, slot_ertn_i, slot_excp_num_i, slot_pc_i,
           slot_instr_i, slot_badva_i, ex_stallreq_i, mem_stallreq_i, dispatch_stallreq_i,
    output commit_mask_o, stall_o, flush_o, excp_flush_o, ertn_flush_o, csr_era_o,
           csr_ecode_o, csr_esubcode_o, va_error_o, bad_va_o, excp_tlbrefill_o,
           excp_tlb_o, excp_tlb_vppn_o, excp_instr_o
  );
endinterface

// File: rtl/commit_ctrl.sv
// In-order commit controller: picks the oldest exception/ertn slot, masks younger commits,
// latches the exception record for the CSR unit and holds a fixed-length flush window.
module commit_ctrl #(
  parameter int COMMIT_WIDTH = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int EXCP_W       = 16
) (
  input logic          clk,
  input logic          rst,
  commit_ctrl_if.slave bus
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [5:0] EC_INT  = 6'h00;
  localparam logic [5:0] EC_PIL  = 6'h01;
  localparam logic [5:0] EC_PIS  = 6'h02;
  localparam logic [5:0] EC_PIF  = 6'h03;
  localparam logic [5:0] EC_PME  = 6'h04;
  localparam logic [5:0] EC_PPI  = 6'h07;
  localparam logic [5:0] EC_ADE  = 6'h08;
  localparam logic [5:0] EC_ALE  = 6'h09;
  localparam logic [5:0] EC_SYS  = 6'h0B;
  localparam logic [5:0] EC_BRK  = 6'h0C;
  localparam logic [5:0] EC_INE  = 6'h0D;
  localparam logic [5:0] EC_IPE  = 6'h0E;
  localparam logic [5:0] EC_TLBR = 6'h3F;
  localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
  localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  typedef struct packed {
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        va_err;
    logic [31:0] bad_va;
    logic        tlbr;
    logic        tlb;
  } cause_t;

  // Lowest set bit of the exception vector selects the cause; fetch-side causes report the PC.
  function automatic cause_t decode_cause(input logic [EXCP_W-1:0] num,
                                          input logic [31:0] pc,
                                          input logic [31:0] badva);
    cause_t c;
    int     sel;
    logic   found;
    logic   src_pc;
    logic   src_va;
    c      = '0;
    sel    = 0;
    found  = 1'b0;
    src_pc = 1'b0;
    src_va = 1'b0;
    for (int b = 0; b < EXCP_W; b++) begin
      if (num[b] && !found) begin
        found = 1'b1;
        sel   = b;
      end
    end
    if (found) begin
      case (sel)
        0:  c.ecode = EC_INT;
        1:  begin c.ecode = EC_ADE;  c.esub = ESUBCODE_ADEF; src_pc = 1'b1; end
        2:  begin c.ecode = EC_TLBR; c.tlbr = 1'b1; c.tlb = 1'b1; src_pc = 1'b1; end
        3:  begin c.ecode = EC_PIF;  c.tlb = 1'b1; src_pc = 1'b1; end
        4:  begin c.ecode = EC_PPI;  c.tlb = 1'b1; src_pc = 1'b1; end
        5:  c.ecode = EC_SYS;
        6:  c.ecode = EC_BRK;
        7:  c.ecode = EC_INE;
        8:  c.ecode = EC_IPE;
        9:  begin c.ecode = EC_ALE;  src_va = 1'b1; end
        10: begin c.ecode = EC_ADE;  c.esub = ESUBCODE_ADEM; src_va = 1'b1; end
        11: begin c.ecode = EC_TLBR; c.tlbr = 1'b1; c.tlb = 1'b1; src_va = 1'b1; end
        12: begin c.ecode = EC_PME;  c.tlb = 1'b1; src_va = 1'b1; end
        13: begin c.ecode = EC_PPI;  c.tlb = 1'b1; src_va = 1'b1; end
        14: begin c.ecode = EC_PIS;  c.tlb = 1'b1; src_va = 1'b1; end
        15: begin c.ecode = EC_PIL;  c.tlb = 1'b1; src_va = 1'b1; end
        default: c = '0;
      endcase
    end
    c.va_err = src_pc | src_va;
    c.bad_va = src_pc ? pc : (src_va ? badva : 32'h0);
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              capture;

  logic [COMMIT_WIDTH-1:0] hit;
  logic [COMMIT_WIDTH-1:0] mask_c;
  logic                    older_hit;
  logic                    win_found;
  logic                    win_excp;
  logic [EXCP_W-1:0]       win_num;
  logic [31:0]             win_pc;
  logic [31:0]             win_instr;
  logic [31:0]             win_badva;
  cause_t                  win_cause;

  logic        kind_excp_q;
  logic [31:0] era_q;
  logic [5:0]  ecode_q;
  logic [8:0]  esub_q;
  logic        va_err_q;
  logic [31:0] bad_va_q;
  logic        tlbr_q;
  logic        tlb_q;
  logic [18:0] vppn_q;
  logic [31:0] instr_q;

  assign hit = bus.slot_valid_i & (bus.slot_excp_i | bus.slot_ertn_i);

  always_comb begin
    older_hit = 1'b0;
    win_found = 1'b0;
    win_excp  = 1'b0;
    win_num   = '0;
    win_pc    = '0;
    win_instr = '0;
    win_badva = '0;
    mask_c    = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      mask_c[i] = bus.slot_valid_i[i] & ~bus.slot_excp_i[i] & ~older_hit & (state_q == S_IDLE);
      if (hit[i] && !win_found) begin
        win_found = 1'b1;
        win_excp  = bus.slot_excp_i[i];
        win_num   = bus.slot_excp_num_i[i*EXCP_W +: EXCP_W];
        win_pc    = bus.slot_pc_i[i*32 +: 32];
        win_instr = bus.slot_instr_i[i*32 +: 32];
        win_badva = bus.slot_badva_i[i*32 +: 32];
      end
      older_hit = older_hit | hit[i];
    end
  end

  assign win_cause = decode_cause(win_num, win_pc, win_badva);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hits seen while flushing belong to the squashed wrong path and are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          capture = 1'b1;
          state_d = S_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_excp_q <= 1'b0;
      era_q       <= '0;
      ecode_q     <= '0;
      esub_q      <= '0;
      va_err_q    <= 1'b0;
      bad_va_q    <= '0;
      tlbr_q      <= 1'b0;
      tlb_q       <= 1'b0;
      vppn_q      <= '0;
      instr_q     <= '0;
    end else if (capture) begin
      kind_excp_q <= win_excp;
      // An ertn only selects the flush flavour; the CSR record keeps the last exception.
      if (win_excp) begin
        era_q    <= win_pc;
        ecode_q  <= win_cause.ecode;
        esub_q   <= win_cause.esub;
        va_err_q <= win_cause.va_err;
        bad_va_q <= win_cause.bad_va;
        tlbr_q   <= win_cause.tlbr;
        tlb_q    <= win_cause.tlb;
        vppn_q   <= win_cause.tlb ? win_cause.bad_va[31:13] : 19'h0;
        instr_q  <= win_instr;
      end
    end
  end

  assign bus.commit_mask_o    = rst ? '0 : mask_c;
  assign bus.flush_o          = (state_q == S_FLUSH);
  assign bus.excp_flush_o     = (state_q == S_FLUSH) &  kind_excp_q;
  assign bus.ertn_flush_o     = (state_q == S_FLUSH) & ~kind_excp_q;
  assign bus.csr_era_o        = era_q;
  assign bus.csr_ecode_o      = ecode_q;
  assign bus.csr_esubcode_o   = esub_q;
  assign bus.va_error_o       = va_err_q;
  assign bus.bad_va_o         = bad_va_q;
  assign bus.excp_tlbrefill_o = tlbr_q;
  assign bus.excp_tlb_o       = tlb_q;
  assign bus.excp_tlb_vppn_o  = vppn_q;
  assign bus.excp_instr_o     = instr_q;

  always_comb begin
    bus.stall_o = 5'b00000;
    if (!rst) begin
      if ((|bus.ex_stallreq_i) || (|bus.mem_stallreq_i)) bus.stall_o = 5'b11110;
      else if (bus.dispatch_stallreq_i)                  bus.stall_o = 5'b11100;
    end
  end

endmodule

// File: doc/commit_ctrl.md
Name: commit_ctrl

Overview:
- Parametrised write-back/commit controller for an N-wide in-order commit stage.
- Selects the oldest faulting or ertn slot and masks every younger slot's regfile write, CSR write and difftest commit.
- Registers the exception record for the CSR unit and holds a multi-cycle flush window that squashes wrong-path commits.
- Also produces the per-stage pipeline stall vector.

Parameters:
- COMMIT_WIDTH, 2: number of commit slots; slot 0 is the oldest.
- FLUSH_CYCLES, 2: cycles that flush_o stays high after an exception/ertn (≥1).
- EXCP_W, 16: width of the per-slot one-hot-priority exception vector.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- slot_valid_i  in  COMMIT_WIDTH  slot holds an instruction
- slot_excp_i  in  COMMIT_WIDTH  slot raised an exception
- slot_ertn_i  in  COMMIT_WIDTH  slot is ertn
- slot_excp_num_i  in  COMMIT_WIDTH*EXCP_W  exception vector; slot i at [i*EXCP_W +: EXCP_W]
- slot_pc_i  in  COMMIT_WIDTH*32  slot PC
- slot_instr_i  in  COMMIT_WIDTH*32  slot instruction word
- slot_badva_i  in  COMMIT_WIDTH*32  memory-side faulting VA (the slot's wdata)
- ex_stallreq_i  in  COMMIT_WIDTH  execute stall request
- mem_stallreq_i  in  COMMIT_WIDTH  mem stall request
- dispatch_stallreq_i  in  1  dispatch stall request
- commit_mask_o  out  COMMIT_WIDTH  slot may write regfile/CSR and commit to difftest
- stall_o  out  5  {ex_mem, dispatch_ex, id_dispatch, if_id, pc}
- flush_o, excp_flush_o, ertn_flush_o  out  1 each  flush controls
- csr_era_o  out  32  exception return address
- csr_ecode_o  out  6  exception code
- csr_esubcode_o  out  9  exception subcode
- va_error_o  out  1  bad_va_o is valid
- bad_va_o  out  32  faulting VA
- excp_tlbrefill_o, excp_tlb_o  out  1 each  TLB refill / TLB-class exception
- excp_tlb_vppn_o  out  19  faulting VPPN
- excp_instr_o  out  32  faulting instruction

Behaviour:
- Reset (clk edge with rst=1): all registered outputs go to 0; flush counter is cleared; FSM enters IDLE. While rst is high, commit_mask_o=0 and stall_o=0.
- Event detection (combinational):
  - hit[i] = slot_valid_i[i] & (slot_excp_i[i] | slot_ertn_i[i]).
  - Winner k = the lowest i with hit[i].
  - commit_mask_o[i] = valid[i] & ~excp[i] & (no hit[j] for any j<i) & (state==IDLE).
  - An ertn slot itself commits. An excepting slot does not.
  - Slots with valid=0 never commit.
- FSM IDLE: if a winner exists in cycle T:
  - Capture the exception record, or the ertn kind, into registers.
  - Move to FLUSH with cnt=FLUSH_CYCLES-1.
  - Outputs become visible in cycle T+1.
- FSM FLUSH:
  - flush_o=1. excp_flush_o=1 if the winner was an exception; otherwise ertn_flush_o=1.
  - Exception when both bits are set in the winning slot: excp takes precedence over ertn.
  - commit_mask_o=0. New hits are ignored.
  - cnt decrements each cycle; leave FLUSH at cnt==0, so the flush is high for exactly FLUSH_CYCLES cycles.
  - Back-to-back: a hit in the first IDLE cycle after FLUSH is accepted normally.
- CSR record registers:
  - Hold their value until the next captured exception.
  - An ertn capture does not modify them.
  - csr_era_o = pc of the winning slot; excp_instr_o = its instr.
  - An all-zero excp_num with excp=1 gives ecode 0, va_error=0.
- Cause decode: the lowest set bit of excp_num wins.

| Bit | ecode | bad_va source | Notes |
|---|---|---|---|
| 0 | INT | none | |
| 1 | ADEF | pc | esub=ESUBCODE_ADEF |
| 2 | TLBR | pc | tlbrefill=1, tlb=1 |
| 3 | PIF | pc | tlb=1 |
| 4 | PPI | pc | tlb=1 |
| 5 | SYS | none | |
| 6 | BRK | none | |
| 7 | INE | none | |
| 8 | IPE | none | |
| 9 | ALE | badva | |
| 10 | ADEM | badva | esub=ESUBCODE_ADEM |
| 11 | TLBR | badva | tlbrefill=1, tlb=1 |
| 12 | PME | badva | tlb=1 |
| 13 | PPI | badva | tlb=1 |
| 14 | PIS | badva | tlb=1 |
| 15 | PIL | badva | tlb=1 |

  - va_error=1 exactly when a bad_va source applies. Otherwise bad_va=0.
  - vppn = bad_va[31:13] when tlb=1, else 0. esubcode=0 unless stated.
- Stall (combinational, not gated by the FSM): any ex_stallreq_i or mem_stallreq_i → 5'b11110; else dispatch_stallreq_i → 5'b11100; else 5'b00000.

Test Plan:
- Reset mid-FLUSH (FLUSH_CYCLES=2, rst in the 1st flush cycle) → flush_o=0 and all CSR outputs 0 on the next cycle; a hit applied after reset is accepted normally.
- Slots 0 and 1 valid, no excp → commit_mask_o=2'b11, flush_o stays 0.
- Slot0 excp_num=16'h0200 (ALE), badva=0x1003, pc=0x1C000100, slot1 valid → commit_mask_o=2'b00.
  - Next cycle: ecode=ALE, bad_va=0x1003, va_error=1, era=0x1C000100, excp_flush_o=1 for 2 cycles.
  - Commits arriving during those 2 cycles are masked.
- Slot0 ertn, slot1 excp (bit 5) → commit_mask_o=2'b01.
  - Next cycle: ertn_flush_o=1, excp_flush_o=0, CSR record unchanged.
- Slot1 excp bit 11, badva=0x8000_2000, slot0 normal → mask=2'b01.
  - Next cycle: ecode=TLBR, tlbrefill=1, tlb=1, vppn=19'h40001, era=slot1 pc.
- Stalls: mem_stallreq_i=2'b10 with dispatch_stallreq_i=1 → stall_o=5'b11110; dispatch_stallreq_i only → 5'b11100; none → 0.
